// File: rtl/cp0_unit_if.sv
// cp0_unit_if: M-stage <-> CP0 signal bundle for the MIPS pipeline.
// master = CPU pipeline side, slave = cp0_unit.
// Optional macro CP0_BADVADDR_EN adds the BadVAddrIn line.
interface cp0_unit_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
`ifdef CP0_BADVADDR_EN
  logic [31:0] BadVAddrIn;
`endif
  logic [31:0] DOut;
  logic [31:0] EPCOut;
  logic        Req;

  modport master (
    output A1, A2, DIn, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
`ifdef CP0_BADVADDR_EN
    output BadVAddrIn,
`endif
    input  DOut, EPCOut, Req
  );

  modport slave (
    input  A1, A2, DIn, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
`ifdef CP0_BADVADDR_EN
    input  BadVAddrIn,
`endif
    output DOut, EPCOut, Req
  );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 at the M stage. Holds SR/Cause/EPC/PRId, raises the
// interrupt/exception request, serves mfc0/mtc0 and supplies EPC for eret.
// Optional macro CP0_BADVADDR_EN adds the read-only BadVAddr register (reg 8).
module cp0_unit #(
  parameter logic [31:0] PRID     = 32'h2023_0001,
  parameter logic [31:0] SR_RESET = 32'h0000_0000
) (
  input logic        clk,
  input logic        reset,
  cp0_unit_if.slave  bus
);

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  // EPC is always word aligned; only [31:2] is stored
  logic [29:0] epc_q, epc_d;
`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_q, badvaddr_d;
`endif

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [31:0] victim_pc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] epc_word;

  // Request generation; suppressed while reset is held
  always_comb begin
    int_req = (|(bus.HWInt & im_q)) & ie_q & ~exl_q;
    exc_req = (bus.ExcCodeIn != 5'd0) & ~exl_q;
    req     = (int_req | exc_req) & ~reset;
  end

  // A delay-slot victim restarts at the branch, one word earlier
  always_comb begin
    victim_pc = bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
  end

  // Next-state: exception entry beats mtc0; eret clears EXL after any SR write
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = bus.HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
`ifdef CP0_BADVADDR_EN
    badvaddr_d = badvaddr_q;
`endif
    if (req) begin
      exl_d      = 1'b1;
      bd_d       = bus.BDIn;
      exc_code_d = int_req ? 5'd0 : bus.ExcCodeIn;
      epc_d      = victim_pc[31:2];
`ifdef CP0_BADVADDR_EN
      if (!int_req && (bus.ExcCodeIn == 5'd4 || bus.ExcCodeIn == 5'd5)) begin
        badvaddr_d = bus.BadVAddrIn;
      end
`endif
    end else begin
      if (bus.WE) begin
        if (bus.A2 == 5'd12) begin
          im_d  = bus.DIn[15:10];
          exl_d = bus.DIn[1];
          ie_d  = bus.DIn[0];
        end else if (bus.A2 == 5'd14) begin
          epc_d = bus.DIn[31:2];
        end
      end
      if (bus.EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= SR_RESET[15:10];
      exl_q      <= SR_RESET[1];
      ie_q       <= SR_RESET[0];
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 30'd0;
`ifdef CP0_BADVADDR_EN
      badvaddr_q <= 32'd0;
`endif
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
`ifdef CP0_BADVADDR_EN
      badvaddr_q <= badvaddr_d;
`endif
    end
  end

  // Register views, mfc0 read mux and eret target with mtc0 EPC bypass
  always_comb begin
    sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    cause_word = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
    epc_word   = {epc_q, 2'b00};
    case (bus.A1)
`ifdef CP0_BADVADDR_EN
      5'd8:    bus.DOut = badvaddr_q;
`endif
      5'd12:   bus.DOut = sr_word;
      5'd13:   bus.DOut = cause_word;
      5'd14:   bus.DOut = epc_word;
      5'd15:   bus.DOut = PRID;
      default: bus.DOut = 32'd0;
    endcase
    if (bus.WE && bus.A2 == 5'd14 && !req) begin
      bus.EPCOut = {bus.DIn[31:2], 2'b00};
    end else begin
      bus.EPCOut = epc_word;
    end
    bus.Req = req;
  end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed bench for cp0_unit with a word-level reference model
// checked every cycle plus literal expectations at key points.
// Honours CP0_BADVADDR_EN when defined.
module tb_cp0_unit;
  localparam logic [31:0] PRID     = 32'h2023_0001;
  localparam logic [31:0] SR_RESET = 32'h0000_0000;
  localparam logic [31:0] SR_MASK  = 32'h0000_FC03;
  localparam logic [31:0] IP_MASK  = 32'h0000_FC00;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  cp0_unit_if bus ();

  cp0_unit #(
    .PRID     (PRID),
    .SR_RESET (SR_RESET)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_sr = 32'd0;
  logic [31:0] m_cause = 32'd0;
  logic [31:0] m_epc = 32'd0;
  logic [31:0] m_badv = 32'd0;
  logic        m_valid = 1'b0;

  function automatic logic m_int();
    return ((bus.HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return !reset && (m_int() || (bus.ExcCodeIn != 5'd0 && !m_sr[1]));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
`ifdef CP0_BADVADDR_EN
      5'd8:    return m_badv;
`endif
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_epcout();
    if (bus.WE && bus.A2 == 5'd14 && !m_req()) return bus.DIn & ~32'd3;
    return m_epc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (m_valid) begin
      check("model_req", {31'd0, bus.Req}, {31'd0, m_req()});
      check("model_dout", bus.DOut, m_read(bus.A1));
      check("model_epcout", bus.EPCOut, m_epcout());
    end
  endtask

  task automatic model_update();
    logic        ir;
    logic        rq;
    logic [31:0] nsr;
    logic [31:0] ncause;
    logic [31:0] nepc;
    ir = m_int();
    rq = m_req();
    if (reset) begin
      m_sr    = SR_RESET & SR_MASK;
      m_cause = 32'd0;
      m_epc   = 32'd0;
      m_badv  = 32'd0;
    end else begin
      nsr    = m_sr;
      nepc   = m_epc;
      ncause = (m_cause & ~IP_MASK) | (32'(bus.HWInt) << 10);
      if (rq) begin
        nsr    = m_sr | 32'd2;
        ncause = (ncause & IP_MASK) | (32'(bus.BDIn) << 31)
               | (ir ? 32'd0 : (32'(bus.ExcCodeIn) << 2));
        nepc   = (bus.BDIn ? bus.VPC - 32'd4 : bus.VPC) & ~32'd3;
`ifdef CP0_BADVADDR_EN
        if (!ir && (bus.ExcCodeIn == 5'd4 || bus.ExcCodeIn == 5'd5)) m_badv = bus.BadVAddrIn;
`endif
      end else begin
        if (bus.WE && bus.A2 == 5'd12) nsr = bus.DIn & SR_MASK;
        if (bus.WE && bus.A2 == 5'd14) nepc = bus.DIn & ~32'd3;
        if (bus.EXLClr) nsr = nsr & ~32'd2;
      end
      m_sr    = nsr;
      m_cause = ncause;
      m_epc   = nepc;
    end
    m_valid = 1'b1;
  endtask

  // Compare at negedge, then advance the model on the edge the DUT sees
  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic peek(input logic [4:0] a, input logic [31:0] exp, input string name);
    bus.A1 = a;
    #1;
    check(name, bus.DOut, exp);
  endtask

  task automatic req_is(input logic exp, input string name);
    #1;
    check(name, {31'd0, bus.Req}, {31'd0, exp});
  endtask

  task automatic clear_exl();
    bus.EXLClr = 1'b1;
    bus.HWInt = 6'd0;
    bus.ExcCodeIn = 5'd0;
    cycle();
    bus.EXLClr = 1'b0;
  endtask

  initial begin
    bus.A1 = 5'd0;
    bus.A2 = 5'd0;
    bus.DIn = 32'd0;
    bus.WE = 1'b0;
    bus.VPC = 32'd0;
    bus.BDIn = 1'b0;
    bus.ExcCodeIn = 5'd0;
    bus.HWInt = 6'b000100;
    bus.EXLClr = 1'b0;
`ifdef CP0_BADVADDR_EN
    bus.BadVAddrIn = 32'd0;
`endif
    @(posedge clk);
    #1;
    req_is(1'b0, "req_during_reset");
    cycle();
    reset = 1'b0;

    // Post-reset register contents
    peek(5'd12, 32'd0, "sr_reset");
    peek(5'd13, 32'd0, "cause_reset");
    peek(5'd14, 32'd0, "epc_reset");
    cycle();
    peek(5'd15, PRID, "prid");
    req_is(1'b0, "req_masked_after_reset");
    bus.HWInt = 6'd0;
    bus.WE = 1'b1;
    bus.A2 = 5'd12;
    bus.DIn = 32'h0000_0401;
    cycle();

    // Enabled interrupt
    bus.WE = 1'b0;
    bus.HWInt = 6'b000001;
    bus.VPC = 32'h3008;
    bus.BDIn = 1'b0;
    req_is(1'b1, "int_req");
    cycle();
    peek(5'd12, 32'h0000_0403, "sr_after_int");
    peek(5'd13, 32'h0000_0400, "cause_after_int");
    peek(5'd14, 32'h0000_3008, "epc_after_int");
    clear_exl();

    // Reserved instruction in a delay slot, interrupt masked
    bus.ExcCodeIn = 5'd10;
    bus.VPC = 32'h3010;
    bus.BDIn = 1'b1;
    bus.HWInt = 6'b000100;
    req_is(1'b1, "exc_req");
    cycle();
    bus.ExcCodeIn = 5'd0;
    bus.BDIn = 1'b0;
    peek(5'd13, 32'h8000_1028, "cause_after_exc");
    peek(5'd14, 32'h0000_300C, "epc_after_exc_bd");

    // EXL blocks both sources
    bus.HWInt = 6'b000001;
    bus.ExcCodeIn = 5'd4;
    req_is(1'b0, "exl_blocks_req");
    cycle();
    peek(5'd14, 32'h0000_300C, "epc_held_under_exl");
    bus.ExcCodeIn = 5'd0;
    bus.EXLClr = 1'b1;
    bus.VPC = 32'h3020;
    req_is(1'b0, "eret_cycle_no_req");
    cycle();
    bus.EXLClr = 1'b0;
    req_is(1'b1, "req_reasserts");
    cycle();
    peek(5'd14, 32'h0000_3020, "epc_reassert");
    clear_exl();

    // mtc0 EPC bypass, then the same write flushed by Req
    bus.WE = 1'b1;
    bus.A2 = 5'd14;
    bus.DIn = 32'h3103;
    #1;
    check("epcout_bypass", bus.EPCOut, 32'h0000_3100);
    cycle();
    bus.WE = 1'b0;
    peek(5'd14, 32'h0000_3100, "epc_written");
    bus.WE = 1'b1;
    bus.DIn = 32'h3203;
    bus.HWInt = 6'b000001;
    bus.VPC = 32'h3040;
    req_is(1'b1, "req_with_mtc0");
    check("epcout_no_bypass", bus.EPCOut, 32'h0000_3100);
    cycle();
    bus.WE = 1'b0;
    bus.HWInt = 6'd0;
    peek(5'd14, 32'h0000_3040, "mtc0_dropped");

    // mtc0 SR with eret: eret clears the written EXL
    bus.WE = 1'b1;
    bus.A2 = 5'd12;
    bus.DIn = 32'h0000_0403;
    bus.EXLClr = 1'b1;
    cycle();
    bus.EXLClr = 1'b0;
    bus.A2 = 5'd13;
    bus.DIn = 32'hFFFF_FFFF;
    peek(5'd12, 32'h0000_0401, "sr_write_with_eret");
    cycle();
    bus.WE = 1'b0;
    peek(5'd13, 32'h0000_0000, "cause_read_only");
    peek(5'd8, 32'd0, "reg8_idle");
    cycle();
    peek(5'd20, 32'd0, "reg20_zero");
    cycle();

`ifdef CP0_BADVADDR_EN
    bus.ExcCodeIn = 5'd4;
    bus.BadVAddrIn = 32'h0000_0007;
    bus.VPC = 32'h3050;
    req_is(1'b1, "adel_req");
    cycle();
    bus.ExcCodeIn = 5'd0;
    peek(5'd8, 32'h0000_0007, "badvaddr_load");
    clear_exl();
    bus.HWInt = 6'b000001;
    bus.BadVAddrIn = 32'h0000_DEAD;
    req_is(1'b1, "int_req_badv");
    cycle();
    bus.HWInt = 6'd0;
    peek(5'd8, 32'h0000_0007, "badvaddr_kept");
    clear_exl();
`endif

    // Reset in the middle of a handler
    bus.ExcCodeIn = 5'd10;
    bus.VPC = 32'h3060;
    req_is(1'b1, "exc_before_reset");
    cycle();
    reset = 1'b1;
    bus.ExcCodeIn = 5'd4;
    bus.HWInt = 6'b000001;
    req_is(1'b0, "req_low_in_reset");
    cycle();
    reset = 1'b0;
    bus.ExcCodeIn = 5'd0;
    bus.HWInt = 6'd0;
    peek(5'd12, 32'd0, "sr_after_mid_reset");
    peek(5'd13, 32'd0, "cause_after_mid_reset");
    peek(5'd14, 32'd0, "epc_after_mid_reset");
    cycle();
    bus.A1 = 5'd15;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
